core_dg_dec: RTL and testbench

//  Receive side of the core data-guard codec. Accepts the 11-bit protected word and returns the 8-bit payload.

---
 rtl/core_dg_dec.sv | 102 ++++++++++
 tb/tb_core_dg_dec.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dg_dec.sv
// core_dg_dec: receive side of the data-guard codec, 11-bit word -> 8-bit payload.
// Hamming(7,4) single-error correction over [10:4]; [3:0] pass through unprotected.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data[10:0] input stream;
//   out_valid/out_ready/out_data[7:0], out_corr, out_syn[2:0] output stream and status;
//   cnt_clr / err_cnt[CNT_W-1:0] saturating corrected-word counter.
// Macro CORE_DG_DEC_ERRCNT_EN builds the counter; otherwise err_cnt is tied to 0.
module core_dg_dec #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_corr,
  output logic [2:0]       out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  logic [10:0] c1;
  logic [2:0]  s1;
  logic        v1;
  logic [2:0]  syn;
  logic        adv1;
  logic        adv2;
  logic [3:0]  pos;
  logic [10:0] fix;
  logic [10:0] cc;
  logic [7:0]  dat;

  assign syn[0] = in_data[4] ^ in_data[6] ^ in_data[8] ^ in_data[10];
  assign syn[1] = in_data[5] ^ in_data[6] ^ in_data[9] ^ in_data[10];
  assign syn[2] = in_data[7] ^ in_data[8] ^ in_data[9] ^ in_data[10];

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  // Syndrome value s names code bit c[3+s] as the flipped one.
  always_comb begin
    pos = {1'b0, s1} + 4'd3;
    fix = '0;
    if (s1 != 3'd0) fix = 11'd1 << pos;
    cc  = c1 ^ fix;
    dat = {cc[10], cc[9], cc[8], cc[6], cc[3:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1 <= 1'b0;
      c1 <= '0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        c1 <= in_data;
        s1 <= syn;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_corr  <= 1'b0;
      out_syn   <= '0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_data <= dat;
        out_corr <= (s1 != 3'd0);
        out_syn  <= s1;
      end
    end
  end

`ifdef CORE_DG_DEC_ERRCNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_corr &&
                 err_cnt != CNT_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = cnt_clr;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_core_dg_dec.sv
// tb_core_dg_dec: randomized and directed bench for core_dg_dec (CNT_W=2).
// Reference model works from Hamming bit positions and a scoreboard queue.
module tb_core_dg_dec;

`ifdef CORE_DG_DEC_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [1:0] CMAX = 2'd3;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_corr;
  logic [2:0]  out_syn;
  logic        cnt_clr;
  logic [1:0]  err_cnt;

  int n_tests;
  int n_fail;
  logic [1:0] exp_cnt;

  core_dg_dec #(.CNT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_corr(out_corr),
    .out_syn(out_syn),
    .cnt_clr(cnt_clr),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hamming position p (1..7) lives at code bit 3+p; parity sits at positions 1,2,4.
  function automatic logic [10:0] encode(input logic [7:0] d);
    logic [10:0] c;
    logic [2:0]  x;
    c = '0;
    c[3:0] = d[3:0];
    c[6] = d[4];
    c[8] = d[5];
    c[9] = d[6];
    c[10] = d[7];
    x = '0;
    for (int p = 1; p <= 7; p++)
      if (c[3+p]) x ^= p[2:0];
    c[4] = x[0];
    c[5] = x[1];
    c[7] = x[2];
    return c;
  endfunction

  // Returns {syn, corr, data}.
  function automatic logic [11:0] model_dec(input logic [10:0] w);
    logic [10:0] c;
    logic [2:0]  x;
    c = w;
    x = '0;
    for (int p = 1; p <= 7; p++)
      if (c[3+p]) x ^= p[2:0];
    if (x != 3'd0) c[3+x] = ~c[3+x];
    return {x, (x != 3'd0), c[10], c[9], c[8], c[6], c[3:0]};
  endfunction

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    exp_cnt = 2'd0;
  endtask

  task automatic send_one(input logic [10:0] w, output logic [7:0] d,
                          output logic cr, output logic [2:0] sy);
    in_data = w;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b required 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b required 1", out_valid);
    end
    d = out_data;
    cr = out_corr;
    sy = out_syn;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    exp_cnt = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid);
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_out_data: got %h required 00", out_data);
    end
    n_tests++;
    if (out_corr !== 1'b0 || out_syn !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_status: corr=%b syn=%0d required 0/0", out_corr, out_syn);
    end
    n_tests++;
    if (err_cnt !== 2'd0) begin
      n_fail++; $display("FAIL rst_err_cnt: got %0d required 0", err_cnt);
    end
  endtask

  task automatic test_clean();
    logic [7:0] d;
    logic cr;
    logic [2:0] sy;
    send_one(11'h525, d, cr, sy);
    n_tests++;
    if (d !== 8'hA5 || cr !== 1'b0 || sy !== 3'd0) begin
      n_fail++;
      $display("FAIL clean: data=%h corr=%b syn=%0d required a5/0/0", d, cr, sy);
    end
  endtask

  task automatic test_correct();
    logic [7:0] d;
    logic cr;
    logic [2:0] sy;
    logic [10:0] w;
    pulse_clr();
    send_one(11'h425, d, cr, sy);
    n_tests++;
    if (d !== 8'hA5 || cr !== 1'b1 || sy !== 3'd5) begin
      n_fail++;
      $display("FAIL correct_c8: data=%h corr=%b syn=%0d required a5/1/5", d, cr, sy);
    end
    n_tests++;
    if (err_cnt !== (CNT_EN ? 2'd1 : 2'd0)) begin
      n_fail++;
      $display("FAIL correct_cnt: got %0d required %0d", err_cnt, CNT_EN ? 1 : 0);
    end
    for (int i = 0; i < 7; i++) begin
      w = 11'h525 ^ (11'd1 << (4 + i));
      send_one(w, d, cr, sy);
      n_tests++;
      if (d !== 8'hA5 || cr !== 1'b1 || sy !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL sweep_c%0d: data=%h corr=%b syn=%0d required a5/1/%0d",
                 4 + i, d, cr, sy, i + 1);
      end
    end
  endtask

  task automatic test_unprotected();
    logic [7:0] d;
    logic cr;
    logic [2:0] sy;
    pulse_clr();
    send_one(11'h521, d, cr, sy);
    n_tests++;
    if (d !== 8'hA1 || cr !== 1'b0 || sy !== 3'd0) begin
      n_fail++;
      $display("FAIL unprot: data=%h corr=%b syn=%0d required a1/0/0", d, cr, sy);
    end
    n_tests++;
    if (err_cnt !== 2'd0) begin
      n_fail++; $display("FAIL unprot_cnt: got %0d required 0", err_cnt);
    end
  endtask

  // Streams n words; rnd selects 50% out_ready, all_corr forces one protected flip.
  task automatic run_stream(input int n, input bit rnd, input bit all_corr,
                            input string tag);
    logic [10:0] words[$];
    logic [11:0] expq[$];
    logic [10:0] w;
    logic [11:0] e;
    int sent;
    int got;
    int cyc;
    int kind;
    bit xfer;
    words.delete();
    expq.delete();
    for (int k = 0; k < n; k++) begin
      w = encode(8'($urandom));
      kind = all_corr ? 1 : int'($urandom_range(0, 3));
      if (kind == 1) w[4 + $urandom_range(0, 6)] ^= 1'b1;
      if (kind == 2) w[$urandom_range(0, 3)] ^= 1'b1;
      if (kind == 3) begin
        w[4] ^= 1'b1;
        w[4 + $urandom_range(1, 6)] ^= 1'b1;
      end
      words.push_back(w);
      expq.push_back(model_dec(w));
    end
    pulse_clr();
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 2000) begin
      in_valid = (sent < n);
      in_data = (sent < n) ? words[sent] : 11'h000;
      out_ready = rnd ? 1'($urandom) : 1'b1;
      @(negedge clk);
      n_tests++;
      if (in_ready !== !((sent - got) == 2 && !out_ready)) begin
        n_fail++;
        $display("FAIL %s_in_ready: got %b in_flight=%0d out_ready=%b",
                 tag, in_ready, sent - got, out_ready);
      end
      n_tests++;
      if (err_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL %s_err_cnt: got %0d required %0d", tag, err_cnt, exp_cnt);
      end
      xfer = out_valid && out_ready;
      if (xfer) begin
        e = expq[got];
        n_tests++;
        if (out_data !== e[7:0] || out_corr !== e[8] || out_syn !== e[11:9]) begin
          n_fail++;
          $display("FAIL %s_word%0d: data=%h corr=%b syn=%0d required %h/%b/%0d",
                   tag, got, out_data, out_corr, out_syn, e[7:0], e[8], e[11:9]);
        end
        if (CNT_EN && e[8] && exp_cnt != CMAX) exp_cnt = exp_cnt + 2'd1;
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s_timeout: received %0d required %0d", tag, got, n);
    end
    if (!rnd) begin
      n_tests++;
      if (cyc != n + 2) begin
        n_fail++;
        $display("FAIL %s_bubbles: cycles %0d required %0d", tag, cyc, n + 2);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: out_valid=%b required 0", tag, out_valid);
    end
    n_tests++;
    if (err_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s_final_cnt: got %0d required %0d", tag, err_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    run_stream(5, 1'b0, 1'b1, "cnt_sat");
    n_tests++;
    if (err_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin
      n_fail++;
      $display("FAIL cnt_sat_value: got %0d required %0d", err_cnt, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_clear_coincident();
    in_data = 11'h425;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_corr !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_setup: valid=%b corr=%b required 1/1", out_valid, out_corr);
    end
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    n_tests++;
    if (err_cnt !== 2'd0) begin
      n_fail++; $display("FAIL clr_wins: got %0d required 0", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic cr;
    logic [2:0] sy;
    pulse_clr();
    send_one(11'h525 ^ 11'h010, d, cr, sy);
    in_data = 11'h0F3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || err_cnt !== 2'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b cnt=%0d data=%h required 0/0/00",
               out_valid, err_cnt, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b required 1", in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_stale%0d: out_valid=%b required 0", k, out_valid);
      end
    end
    @(posedge clk); #1;
    send_one(11'h525, d, cr, sy);
    n_tests++;
    if (d !== 8'hA5 || cr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_after: data=%h corr=%b required a5/0", d, cr);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_clean();
    test_correct();
    test_unprotected();
    run_stream(16, 1'b0, 1'b0, "full_rate");
    run_stream(16, 1'b1, 1'b0, "backpressure");
    run_stream(40, 1'b1, 1'b0, "random");
    test_counter();
    test_clear_coincident();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
